// File: rtl/serial_101_frame_tx.sv
// Serial frame transmitter: preamble 1,0,1, then DATA_W payload bits MSB-first,
// then GAP_CYCLES forced-zero bits, one bit per clock on x.
module serial_101_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              x,
  output logic              tx_busy,
  output logic              sof,
  output logic              eof
);

  localparam int BW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              x_q, x_d;
  logic              busy_q, busy_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic [1:0]        pre_q, pre_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [3:0]        gap_q, gap_d;
  logic [DATA_W-1:0] sh_q, sh_d;

  assign data_ready = (state_q == ST_IDLE);
  assign x          = x_q;
  assign tx_busy    = busy_q;
  assign sof        = sof_q;
  assign eof        = eof_q;

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      pre_q   <= 2'd0;
      bit_q   <= '0;
      gap_q   <= 4'd0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      pre_q   <= pre_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
    end
  end

  // Next-state logic: each state's registered outputs describe the bit emitted next.
  always_comb begin
    state_d = state_q;
    x_d     = 1'b0;
    busy_d  = busy_q;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    pre_d   = pre_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    case (state_q)
      ST_IDLE: begin
        if (data_valid) begin
          state_d = ST_PRE;
          x_d     = 1'b1;
          sof_d   = 1'b1;
          busy_d  = 1'b1;
          pre_d   = 2'd0;
          sh_d    = data_in;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_PRE: begin
        case (pre_q)
          2'd0: begin
            x_d   = 1'b0;
            pre_d = 2'd1;
          end
          2'd1: begin
            x_d   = 1'b1;
            pre_d = 2'd2;
          end
          default: begin
            // Last preamble bit is on x; the MSB follows directly.
            state_d = ST_DATA;
            x_d     = sh_q[DATA_W-1];
            sh_d    = sh_q << 1;
            bit_d   = BW'(DATA_W - 1);
            eof_d   = (DATA_W == 1);
            pre_d   = 2'd0;
          end
        endcase
      end
      ST_DATA: begin
        if (bit_q != '0) begin
          x_d   = sh_q[DATA_W-1];
          sh_d  = sh_q << 1;
          bit_d = bit_q - BW'(1);
          eof_d = (bit_q == BW'(1));
        end else if (GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          gap_d   = 4'(GAP_CYCLES - 1);
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_d   = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_101_frame_tx.sv
// Bench for serial_101_frame_tx: queue-based frame model for an 8-bit/gap-2
// instance plus directed checks on a 1-bit/gap-0 instance.
module tb_serial_101_frame_tx;
  localparam int W = 8;
  localparam int G = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready, x, tx_busy, sof, eof;
  logic [0:0]   d2_data;
  logic         d2_valid;
  logic         d2_ready, d2_x, d2_busy, d2_sof, d2_eof;

  always #5 clk = ~clk;

  serial_101_frame_tx #(.DATA_W(W), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .x(x), .tx_busy(tx_busy), .sof(sof), .eof(eof));

  serial_101_frame_tx #(.DATA_W(1), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .data_in(d2_data), .data_valid(d2_valid),
    .data_ready(d2_ready), .x(d2_x), .tx_busy(d2_busy), .sof(d2_sof), .eof(d2_eof));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of bits tagged with sof (bit1) / eof (bit2).
  int q[$];
  bit m_busy = 1'b0, m_x = 1'b0, m_sof = 1'b0, m_eof = 1'b0;
  int fc = 0, det = 0, det_at = -1;
  logic [2:0] hist = 3'b000;

  task automatic model_edge();
    int c;
    m_x = 1'b0; m_sof = 1'b0; m_eof = 1'b0;
    if (!reset_n) begin
      q.delete(); m_busy = 1'b0;
      return;
    end
    if (!m_busy && data_valid) begin
      q.delete();
      q.push_back(3); q.push_back(0); q.push_back(1);
      for (int i = W - 1; i >= 0; i--) q.push_back(int'(data_in[i]) + ((i == 0) ? 4 : 0));
      for (int i = 0; i < G; i++) q.push_back(0);
      m_busy = 1'b1;
    end
    if (m_busy) begin
      if (q.size() > 0) begin
        c = q.pop_front();
        m_x = c[0]; m_sof = c[1]; m_eof = c[2];
      end else begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("x", x, m_x);
    check("tx_busy", tx_busy, m_busy);
    check("sof", sof, m_sof);
    check("eof", eof, m_eof);
    check("data_ready", data_ready, !m_busy);
    fc++;
    hist = {hist[1:0], x};
    if (hist == 3'b101) begin
      det++; det_at = fc;
    end
  endtask

  task automatic drain();
    data_valid = 1'b0;
    for (int i = 0; i < 40 && m_busy; i++) step();
    check("drain_idle", tx_busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish, required finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    logic [12:0] a5_obs;
    logic [4:0]  pat;
    reset_n = 1'b0; data_valid = 1'b0; data_in = '0; d2_valid = 1'b0; d2_data = 1'b0;
    #1;
    check("rst_x", x, 1'b0);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_sof", sof, 1'b0);
    check("rst_eof", eof, 1'b0);
    check("rst_d2_x", d2_x, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_ready", data_ready, 1'b1);
    step();

    // A5 frame against the literal expected bit sequence.
    data_valid = 1'b1; data_in = 8'hA5;
    a5_obs = '0;
    step();
    a5_obs = {a5_obs[11:0], x};
    data_valid = 1'b0;
    for (int i = 1; i < 13; i++) begin
      data_in = 8'($urandom);
      step();
      a5_obs = {a5_obs[11:0], x};
    end
    check("a5_frame", a5_obs, 13'b1011010010100);
    step();
    check("a5_ready_after", data_ready, 1'b1);

    // Back-to-back frames with data_valid held high.
    data_valid = 1'b1; data_in = 8'hFF;
    step();
    data_in = 8'h00;
    repeat (27) step();
    drain();

    // Loopback through a 101 detector on a 0x00 payload.
    repeat (3) step();
    det = 0; det_at = -1; fc = -1;
    data_valid = 1'b1; data_in = 8'h00;
    step();
    data_valid = 1'b0;
    repeat (16) step();
    check("det_count", det, 1);
    check("det_pos", det_at, 2);

    // Reset at the 4th data bit of 0xC3.
    data_valid = 1'b1; data_in = 8'hC3;
    step();
    data_valid = 1'b0;
    repeat (6) step();
    check("c3_4th_bit", x, 1'b0);
    reset_n = 1'b0;
    #1;
    model_edge();
    check("abort_x", x, 1'b0);
    check("abort_busy", tx_busy, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) step();

    // Random traffic: data_in changes every cycle, valid asserted at random.
    for (int i = 0; i < 2000; i++) begin
      data_valid = ($urandom_range(0, 3) != 0);
      data_in    = 8'($urandom);
      step();
    end
    drain();

    // One-bit payload, no gap.
    d2_valid = 1'b1; d2_data = 1'b1;
    @(posedge clk); @(negedge clk);
    d2_valid = 1'b0;
    check("w1_x0", d2_x, 1'b1);
    check("w1_sof0", d2_sof, 1'b1);
    check("w1_eof0", d2_eof, 1'b0);
    @(posedge clk); @(negedge clk);
    check("w1_x1", d2_x, 1'b0);
    @(posedge clk); @(negedge clk);
    check("w1_x2", d2_x, 1'b1);
    check("w1_eof2", d2_eof, 1'b0);
    @(posedge clk); @(negedge clk);
    check("w1_x3", d2_x, 1'b1);
    check("w1_eof3", d2_eof, 1'b1);
    check("w1_sof3", d2_sof, 1'b0);
    check("w1_busy3", d2_busy, 1'b1);
    @(posedge clk); @(negedge clk);
    check("w1_x4", d2_x, 1'b0);
    check("w1_busy4", d2_busy, 1'b0);
    check("w1_ready4", d2_ready, 1'b1);
    pat = 5'b10110;
    d2_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); @(negedge clk);
      check("w1_stream_x", d2_x, pat[4 - (i % 5)]);
      check("w1_sof_eof", d2_sof & d2_eof, 1'b0);
    end
    d2_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
